// File: rtl/queue_merge_pkg.sv
// Shared types and sizing helpers for the queue merge arbiter.
package queue_merge_pkg;

    // Arbitration FSM: IDLE picks round-robin, LOCKED holds one requester
    // until the last beat of its packet has been enqueued.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } queue_merge_state_e;

    // Width of one queue entry: {src, last, msg}.
    function automatic int queue_merge_entry_nbits(input int num_reqs, input int msg_nbits);
        return $clog2(num_reqs) + 1 + msg_nbits;
    endfunction

endpackage

// File: rtl/queue_merge_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping N-1 -> 0 explicitly so N need not be a power of two.
module queue_merge_rr_pick #(
    parameter int p_num_reqs  = 4,
    parameter int p_idx_nbits = $clog2(p_num_reqs)
) (
    input  logic [p_num_reqs-1:0]  val,
    input  logic [p_idx_nbits-1:0] ptr,
    output logic [p_num_reqs-1:0]  grant,
    output logic [p_idx_nbits-1:0] idx,
    output logic                   any
);

    localparam logic [p_idx_nbits:0] LP_N = (p_idx_nbits+1)'(p_num_reqs);

    logic [p_idx_nbits:0]   w_sum;
    logic [p_idx_nbits-1:0] w_cand;
    logic                   w_hit;

    // Walk candidates in priority order; the first valid one wins.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        w_hit  = 1'b0;
        for (int k = 0; k < p_num_reqs; k++) begin
            w_sum  = {1'b0, ptr} + (p_idx_nbits+1)'(k);
            w_cand = (w_sum >= LP_N) ? p_idx_nbits'(w_sum - LP_N) : p_idx_nbits'(w_sum);
            w_hit  = !any && val[w_cand];
            grant[w_cand] = grant[w_cand] | w_hit;
            idx    = w_hit ? w_cand : idx;
            any    = any | w_hit;
        end
    end

endmodule

// File: rtl/vc_Queue.sv
// Small synchronous FIFO in the vc_Queue library style. The NORMAL flavour
// has no bypass and no pipelining: enq_rdy depends only on occupancy.
`ifndef VC_QUEUE_NORMAL
`define VC_QUEUE_NORMAL 4'b0000
`endif
`ifndef VC_QUEUE_PIPE
`define VC_QUEUE_PIPE 4'b0001
`endif

module vc_Queue #(
    parameter logic [3:0] p_type      = `VC_QUEUE_NORMAL,
    parameter int         p_msg_nbits = 1,
    parameter int         p_num_msgs  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enq_val,
    output logic                   enq_rdy,
    input  logic [p_msg_nbits-1:0] enq_msg,
    output logic                   deq_val,
    input  logic                   deq_rdy,
    output logic [p_msg_nbits-1:0] deq_msg
);

    localparam int LP_AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int LP_CW = $clog2(p_num_msgs + 1);
    localparam logic [LP_AW-1:0] LP_LAST_SLOT = LP_AW'(p_num_msgs - 1);
    localparam logic [LP_CW-1:0] LP_FULL      = LP_CW'(p_num_msgs);
    localparam logic             LP_PIPE      = p_type[0];

    logic [p_msg_nbits-1:0] r_mem [p_num_msgs];
    logic [LP_AW-1:0]       r_head;
    logic [LP_AW-1:0]       r_tail;
    logic [LP_CW-1:0]       r_count;
    logic                   w_full;
    logic                   w_do_enq;
    logic                   w_do_deq;

    assign w_full   = (r_count == LP_FULL);
    assign deq_val  = (r_count != LP_CW'(0));
    assign enq_rdy  = !w_full || (LP_PIPE && deq_rdy);
    assign deq_msg  = r_mem[r_head];
    assign w_do_enq = enq_val && enq_rdy;
    assign w_do_deq = deq_val && deq_rdy;

    // Storage, circular pointers with explicit wrap, and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < p_num_msgs; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_enq) begin
                r_mem[r_tail] <= enq_msg;
                r_tail        <= (r_tail == LP_LAST_SLOT) ? LP_AW'(0) : r_tail + LP_AW'(1);
            end
            if (w_do_deq) begin
                r_head <= (r_head == LP_LAST_SLOT) ? LP_AW'(0) : r_head + LP_AW'(1);
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + LP_CW'(1);
                2'b01:   r_count <= r_count - LP_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/queue_merge_arbiter.sv
// Merges several val/rdy packet streams into one queue. Round-robin grant,
// held for a whole packet; each beat is tagged with its source and last flag.
`ifndef VC_QUEUE_NORMAL
`define VC_QUEUE_NORMAL 4'b0000
`endif

module queue_merge_arbiter
    import queue_merge_pkg::*;
#(
    parameter int p_num_reqs  = 4,
    parameter int p_msg_nbits = 32,
    parameter int p_num_msgs  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             istream_val,
    output logic [p_num_reqs-1:0]             istream_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0] istream_msg,
    input  logic [p_num_reqs-1:0]             istream_last,
    output logic                              ostream_val,
    input  logic                              ostream_rdy,
    output logic [p_msg_nbits-1:0]            ostream_msg,
    output logic [$clog2(p_num_reqs)-1:0]     ostream_src,
    output logic                              ostream_last
);

    localparam int LP_SRC_NBITS   = $clog2(p_num_reqs);
    localparam int LP_ENTRY_NBITS = queue_merge_entry_nbits(p_num_reqs, p_msg_nbits);
    localparam logic [p_num_reqs-1:0]   LP_ONE     = {{(p_num_reqs-1){1'b0}}, 1'b1};
    localparam logic [LP_SRC_NBITS-1:0] LP_LAST_ID = LP_SRC_NBITS'(p_num_reqs - 1);

    queue_merge_state_e        r_state;
    logic [LP_SRC_NBITS-1:0]   r_ptr;
    logic [LP_SRC_NBITS-1:0]   r_lock_id;

    logic [p_num_reqs-1:0]     w_pick_grant;
    logic [LP_SRC_NBITS-1:0]   w_pick_idx;
    logic                      w_pick_any;
    logic [LP_SRC_NBITS-1:0]   w_sel;
    logic [p_num_reqs-1:0]     w_sel_onehot;
    logic                      w_sel_act;
    logic [LP_SRC_NBITS-1:0]   w_ptr_next;
    logic                      w_xfer;
    logic                      w_enq_rdy;
    logic [LP_ENTRY_NBITS-1:0] w_enq_msg;
    logic [LP_ENTRY_NBITS-1:0] w_deq_msg;

    queue_merge_rr_pick #(
        .p_num_reqs (p_num_reqs),
        .p_idx_nbits(LP_SRC_NBITS)
    ) u_pick (
        .val  (istream_val),
        .ptr  (r_ptr),
        .grant(w_pick_grant),
        .idx  (w_pick_idx),
        .any  (w_pick_any)
    );

    // Choose the requester currently allowed to enqueue.
    always_comb begin
        w_sel        = r_lock_id;
        w_sel_act    = 1'b0;
        w_sel_onehot = '0;
        case (r_state)
            IDLE: begin
                w_sel        = w_pick_idx;
                w_sel_act    = w_pick_any;
                w_sel_onehot = w_pick_grant;
            end
            LOCKED: begin
                w_sel        = r_lock_id;
                w_sel_act    = 1'b1;
                w_sel_onehot = LP_ONE << r_lock_id;
            end
            default: begin
                w_sel        = r_lock_id;
                w_sel_act    = 1'b0;
                w_sel_onehot = '0;
            end
        endcase
    end

    // Steer queue readiness to the selected requester; nothing is ready in reset.
    always_comb begin
        if (reset && w_sel_act && w_enq_rdy) begin
            istream_rdy = w_sel_onehot;
        end else begin
            istream_rdy = '0;
        end
    end

    assign w_xfer     = w_sel_act && istream_val[w_sel] && istream_rdy[w_sel];
    assign w_ptr_next = (w_sel == LP_LAST_ID) ? LP_SRC_NBITS'(0) : w_sel + LP_SRC_NBITS'(1);
    assign w_enq_msg  = {w_sel, istream_last[w_sel],
                         istream_msg[int'(w_sel)*p_msg_nbits +: p_msg_nbits]};

    // Arbitration state advances only on an accepted beat, so a full queue freezes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_lock_id <= '0;
        end else if (w_xfer) begin
            if (istream_last[w_sel]) begin
                r_state <= IDLE;
                r_ptr   <= w_ptr_next;
            end else begin
                r_state   <= LOCKED;
                r_lock_id <= w_sel;
            end
        end
    end

    vc_Queue #(
        .p_type     (`VC_QUEUE_NORMAL),
        .p_msg_nbits(LP_ENTRY_NBITS),
        .p_num_msgs (p_num_msgs)
    ) u_queue (
        .clk    (clk),
        .reset  (reset),
        .enq_val(w_xfer),
        .enq_rdy(w_enq_rdy),
        .enq_msg(w_enq_msg),
        .deq_val(ostream_val),
        .deq_rdy(ostream_rdy),
        .deq_msg(w_deq_msg)
    );

    assign ostream_src  = w_deq_msg[LP_ENTRY_NBITS-1 -: LP_SRC_NBITS];
    assign ostream_last = w_deq_msg[p_msg_nbits];
    assign ostream_msg  = w_deq_msg[p_msg_nbits-1:0];

endmodule

// File: tb/tb_queue_merge_arbiter.sv
// Self-checking bench for queue_merge_arbiter (N=4, 32-bit payload, depth 2).
// A queue-based reference model applies the arbitration rules directly.
module tb_queue_merge_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   istream_val;
    logic [N-1:0]   istream_rdy;
    logic [N*W-1:0] istream_msg;
    logic [N-1:0]   istream_last;
    logic           ostream_val;
    logic           ostream_rdy;
    logic [W-1:0]   ostream_msg;
    logic [1:0]     ostream_src;
    logic           ostream_last;

    always #5 clk = ~clk;

    queue_merge_arbiter #(.p_num_reqs(N), .p_msg_nbits(W), .p_num_msgs(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .istream_last(istream_last),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_src (ostream_src),
        .ostream_last(ostream_last)
    );

    typedef struct {
        logic [1:0]   src;
        logic         last;
        logic [W-1:0] msg;
    } beat_t;

    beat_t m_q[$];
    int    m_ptr;
    bit    m_locked;
    int    m_lock;
    int    last_xfer;
    int    n_cmp;
    int    n_err;

    // Expected readiness straight from the arbitration rules.
    function automatic logic [N-1:0] exp_rdy();
        logic [N-1:0] r;
        r = '0;
        if (m_q.size() >= D) return r;
        if (m_locked) begin
            r[m_lock] = 1'b1;
            return r;
        end
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (istream_val[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Advance one clock and update the model with what should have happened.
    task automatic tick();
        logic [N-1:0] r;
        beat_t        b;
        bit           deq;
        r = exp_rdy();
        last_xfer = -1;
        for (int i = 0; i < N; i++) if (r[i] && istream_val[i]) last_xfer = i;
        deq = (m_q.size() > 0) && ostream_rdy;
        b.src = 2'd0; b.last = 1'b0; b.msg = '0;
        if (last_xfer >= 0) begin
            b.src  = 2'(last_xfer);
            b.last = istream_last[last_xfer];
            b.msg  = istream_msg[last_xfer*W +: W];
        end
        @(posedge clk);
        if (deq) void'(m_q.pop_front());
        if (last_xfer >= 0) begin
            m_q.push_back(b);
            if (b.last) begin
                m_ptr    = (last_xfer + 1) % N;
                m_locked = 1'b0;
            end else begin
                m_locked = 1'b1;
                m_lock   = last_xfer;
            end
        end
        #1;
    endtask

    task automatic new_msg(input int i);
        istream_msg[i*W +: W] = $urandom();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        istream_val  = '0;
        istream_last = '0;
        ostream_rdy  = 1'b1;
        for (int i = 0; i < N; i++) new_msg(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_q.delete();
        m_ptr    = 0;
        m_locked = 1'b0;
        m_lock   = 0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        istream_val  = 4'b1111;
        istream_last = 4'b1111;
        #2;
        n_cmp++;
        if (ostream_val !== 1'b0) begin n_err++; $display("FAIL reset_oval: got %b want 0", ostream_val); end
        n_cmp++;
        if (istream_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_rdy: got %b want 0000", istream_rdy); end
        do_reset();
        istream_val  = 4'b1111;
        istream_last = 4'b1111;
        #1;
        n_cmp++;
        if (ostream_val !== 1'b0) begin n_err++; $display("FAIL reset_empty: got %b want 0", ostream_val); end
        n_cmp++;
        if (istream_rdy !== 4'b0001) begin n_err++; $display("FAIL reset_ptr0: got %b want 0001", istream_rdy); end
    endtask

    task automatic test_fairness();
        int obs[$];
        int first_val;
        do_reset();
        first_val    = -1;
        istream_val  = 4'b1111;
        istream_last = 4'b1111;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_cmp++;
            if (istream_rdy !== exp_rdy()) begin n_err++; $display("FAIL fair_rdy c%0d: got %b want %b", c, istream_rdy, exp_rdy()); end
            n_cmp++;
            if (m_q.size() == 0) begin
                if (ostream_val !== 1'b0) begin n_err++; $display("FAIL fair_head c%0d: val %b want 0", c, ostream_val); end
            end else if (ostream_val !== 1'b1 || {ostream_src, ostream_last, ostream_msg} !== {m_q[0].src, m_q[0].last, m_q[0].msg}) begin
                n_err++; $display("FAIL fair_head c%0d: got %b/%0d/%h want 1/%0d/%h", c, ostream_val, ostream_src, ostream_msg, m_q[0].src, m_q[0].msg);
            end
            if (ostream_val === 1'b1) begin
                obs.push_back(int'(ostream_src));
                if (first_val < 0) first_val = c;
            end
            tick();
            if (last_xfer >= 0) new_msg(last_xfer);
        end
        n_cmp++;
        if (first_val != 1) begin n_err++; $display("FAIL fair_latency: got %0d want 1", first_val); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (k >= obs.size() || obs[k] != k % 4) begin
                n_err++; $display("FAIL fair_seq[%0d]: got %0d want %0d", k, (k < obs.size()) ? obs[k] : -1, k % 4);
            end
        end
        istream_val = '0;
        repeat (3) tick();
    endtask

    task automatic test_packet_lock();
        int obs[$];
        int beats2;
        logic [N-1:0] want;
        int exp_src[5];
        exp_src = '{1, 2, 2, 2, 3};
        do_reset();
        istream_val  = 4'b0010;
        istream_last = 4'b0010;
        tick();
        new_msg(1);
        istream_val  = 4'b1111;
        istream_last = 4'b1011;
        beats2 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            want = (c < 3) ? 4'b0100 : 4'b1000;
            n_cmp++;
            if (istream_rdy !== want || istream_rdy !== exp_rdy()) begin
                n_err++; $display("FAIL lock_rdy c%0d: got %b want %b", c, istream_rdy, want);
            end
            if (ostream_val === 1'b1) obs.push_back(int'(ostream_src));
            tick();
            if (last_xfer >= 0) new_msg(last_xfer);
            if (last_xfer == 2) begin
                beats2++;
                if (beats2 == 2) istream_last[2] = 1'b1;
            end
        end
        istream_val = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ostream_val === 1'b1) obs.push_back(int'(ostream_src));
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (k >= obs.size() || obs[k] != exp_src[k]) begin
                n_err++; $display("FAIL lock_src[%0d]: got %0d want %0d", k, (k < obs.size()) ? obs[k] : -1, exp_src[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] acc[$];
        logic [W-1:0] cur;
        logic [N-1:0] want;
        do_reset();
        ostream_rdy  = 1'b0;
        istream_val  = 4'b0010;
        istream_last = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            #1;
            want = (c < 2) ? 4'b0010 : 4'b0000;
            n_cmp++;
            if (istream_rdy !== want) begin n_err++; $display("FAIL bp_rdy c%0d: got %b want %b", c, istream_rdy, want); end
            cur = istream_msg[1*W +: W];
            tick();
            if (last_xfer == 1) begin
                acc.push_back(cur);
                new_msg(1);
            end
        end
        n_cmp++;
        if (acc.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d want 2", acc.size()); end
        ostream_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (istream_rdy !== exp_rdy()) begin n_err++; $display("FAIL bp_drain_rdy c%0d: got %b want %b", c, istream_rdy, exp_rdy()); end
            n_cmp++;
            if (m_q.size() == 0) begin
                if (ostream_val !== 1'b0) begin n_err++; $display("FAIL bp_head c%0d: val %b want 0", c, ostream_val); end
            end else if (ostream_val !== 1'b1 || {ostream_src, ostream_msg} !== {m_q[0].src, m_q[0].msg}) begin
                n_err++; $display("FAIL bp_head c%0d: got %b/%0d/%h want 1/%0d/%h", c, ostream_val, ostream_src, ostream_msg, m_q[0].src, m_q[0].msg);
            end
            if (c < 2 && acc.size() == 2) begin
                n_cmp++;
                if (ostream_msg !== acc[c] || istream_rdy !== ((c == 0) ? 4'b0000 : 4'b0010)) begin
                    n_err++; $display("FAIL bp_order c%0d: got %h rdy %b want %h", c, ostream_msg, istream_rdy, acc[c]);
                end
            end
            tick();
            if (last_xfer >= 0) new_msg(last_xfer);
        end
        istream_val = '0;
        repeat (3) tick();
    endtask

    task automatic test_wrap_idle();
        do_reset();
        istream_val  = 4'b0100;
        istream_last = 4'b0100;
        tick();
        istream_val  = 4'b0001;
        istream_last = 4'b0001;
        #1;
        n_cmp++;
        if (istream_rdy !== 4'b0001) begin n_err++; $display("FAIL wrap_grant0: got %b want 0001", istream_rdy); end
        tick();
        istream_val = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (istream_rdy !== 4'b0000) begin n_err++; $display("FAIL idle_rdy c%0d: got %b want 0000", c, istream_rdy); end
            tick();
        end
        n_cmp++;
        if (ostream_val !== 1'b0) begin n_err++; $display("FAIL idle_empty: got %b want 0", ostream_val); end
        istream_val  = 4'b0011;
        istream_last = 4'b0011;
        #1;
        n_cmp++;
        if (istream_rdy !== 4'b0010) begin n_err++; $display("FAIL wrap_ptr1: got %b want 0010", istream_rdy); end
        istream_val = '0;
        repeat (2) tick();
    endtask

    task automatic test_lock_stall();
        do_reset();
        istream_val  = 4'b0010;
        istream_last = 4'b0000;
        tick();
        new_msg(1);
        istream_val  = 4'b0001;
        istream_last = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (istream_rdy !== 4'b0010) begin n_err++; $display("FAIL stall_rdy c%0d: got %b want 0010", c, istream_rdy); end
            tick();
        end
        istream_val  = 4'b0011;
        istream_last = 4'b0011;
        #1;
        n_cmp++;
        if (istream_rdy !== 4'b0010) begin n_err++; $display("FAIL stall_last: got %b want 0010", istream_rdy); end
        tick();
        istream_val = 4'b0001;
        #1;
        n_cmp++;
        if (istream_rdy !== 4'b0001) begin n_err++; $display("FAIL stall_release: got %b want 0001", istream_rdy); end
        tick();
        istream_val = '0;
        repeat (3) tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        ostream_rdy  = 1'b0;
        istream_val  = 4'b0010;
        istream_last = 4'b0000;
        tick();
        new_msg(1);
        tick();
        n_cmp++;
        if (ostream_val !== 1'b1 || m_q.size() != 2) begin n_err++; $display("FAIL ar_pre: val %b model %0d want 1/2", ostream_val, m_q.size()); end
        istream_val = 4'b1111;
        #3;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ostream_val !== 1'b0) begin n_err++; $display("FAIL ar_oval: got %b want 0", ostream_val); end
        n_cmp++;
        if (istream_rdy !== 4'b0000) begin n_err++; $display("FAIL ar_rdy: got %b want 0000", istream_rdy); end
        @(negedge clk);
        reset = 1'b1;
        m_q.delete();
        m_ptr    = 0;
        m_locked = 1'b0;
        ostream_rdy  = 1'b1;
        istream_last = 4'b1111;
        #1;
        n_cmp++;
        if (ostream_val !== 1'b0 || istream_rdy !== 4'b0001) begin
            n_err++; $display("FAIL ar_after: val %b rdy %b want 0/0001", ostream_val, istream_rdy);
        end
        tick();
        n_cmp++;
        if (ostream_val !== 1'b1 || ostream_src !== 2'd0) begin n_err++; $display("FAIL ar_first: val %b src %0d want 1/0", ostream_val, ostream_src); end
        istream_val = '0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!istream_val[i] && ($urandom_range(2) == 0)) begin
                    istream_val[i]  = 1'b1;
                    istream_last[i] = ($urandom_range(2) != 0);
                    new_msg(i);
                end
            end
            ostream_rdy = ($urandom_range(3) != 0);
            #1;
            n_cmp++;
            if (istream_rdy !== exp_rdy()) begin n_err++; $display("FAIL rand_rdy c%0d: got %b want %b", c, istream_rdy, exp_rdy()); end
            n_cmp++;
            if (m_q.size() == 0) begin
                if (ostream_val !== 1'b0) begin n_err++; $display("FAIL rand_head c%0d: val %b want 0", c, ostream_val); end
            end else if (ostream_val !== 1'b1 || {ostream_src, ostream_last, ostream_msg} !== {m_q[0].src, m_q[0].last, m_q[0].msg}) begin
                n_err++; $display("FAIL rand_head c%0d: got %b/%0d/%b/%h want 1/%0d/%b/%h", c, ostream_val, ostream_src, ostream_last, ostream_msg, m_q[0].src, m_q[0].last, m_q[0].msg);
            end
            tick();
            if (last_xfer >= 0) istream_val[last_xfer] = 1'b0;
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        m_ptr    = 0;
        m_locked = 1'b0;
        m_lock   = 0;
        istream_msg = '0;
        ostream_rdy = 1'b1;
        test_reset();
        test_fairness();
        test_packet_lock();
        test_backpressure();
        test_wrap_idle();
        test_lock_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
